// File: rtl/reg_scoreboard_pipe.sv
// Register-hazard scoreboard: tracks pending writes from decode to writeback
// and raises the decode stall when a read address matches an in-flight write.

module reg_sb_hz #(
  parameter int AW  = 5,
  parameter int NWR = 2,
  parameter int NRD = 2,
  parameter bit CHK = 1'b1
) (
  input  logic               vld,
  input  logic [NWR-1:0]     wen,
  input  logic [NWR*AW-1:0]  wa,
  input  logic [NRD-1:0]     rd_en,
  input  logic [NRD*AW-1:0]  rd_a,
  output logic               hit
);
  logic [NWR-1:0][NRD-1:0] m;

  always_comb begin
    m = '0;
    for (int p = 0; p < NWR; p++)
      for (int j = 0; j < NRD; j++)
        m[p][j] = wen[p] & rd_en[j] & (wa[p*AW +: AW] == rd_a[j*AW +: AW]);
  end

  // CHK=0 marks a stage whose write the register file already forwards
  assign hit = CHK & vld & (|m);
endmodule

module reg_scoreboard_pipe #(
  parameter int AW         = 5,
  parameter int NSTAGES    = 3,
  parameter int NWR        = 2,
  parameter int NRD        = 2,
  parameter int KILL_STAGE = 1,
  parameter int WT_BYPASS  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             issue_valid,
  input  logic [NWR-1:0]                   issue_wen,
  input  logic [NWR*AW-1:0]                issue_wa,
  input  logic [NRD-1:0]                   rd_en,
  input  logic [NRD*AW-1:0]                rd_a,
  input  logic                             cancel,
  input  logic                             flush,
  input  logic                             clr_cnt,
  output logic                             stall,
  output logic [NSTAGES-1:0]               hz_stage,
  output logic [$clog2(NSTAGES+1)-1:0]     pend_cnt,
  output logic [15:0]                      stall_cycles
);
  localparam int CW = $clog2(NSTAGES+1);

  typedef struct packed {
    logic              vld;
    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] wa;
  } ent_t;

  ent_t [NSTAGES-1:0]          ent_q, ent_d;
  logic [NSTAGES-1:0][NWR-1:0] wen_eff;
  logic [CW-1:0]               pend_q, pend_d;
  logic [15:0]                 stall_cycles_q, stall_cycles_d;

  always_comb begin
    for (int k = 0; k < NSTAGES; k++) wen_eff[k] = ent_q[k].wen;
    if (cancel) wen_eff[KILL_STAGE] = '0;
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    reg_sb_hz #(
      .AW (AW),
      .NWR(NWR),
      .NRD(NRD),
      .CHK(k <= NSTAGES - 1 - WT_BYPASS)
    ) u_hz (
      .vld  (ent_q[k].vld),
      .wen  (wen_eff[k]),
      .wa   (ent_q[k].wa),
      .rd_en(rd_en),
      .rd_a (rd_a),
      .hit  (hz_stage[k])
    );
  end

  assign stall = issue_valid & (|hz_stage);

  // shift with cancel folded in; flush kills everything younger than KILL_STAGE
  always_comb begin
    ent_d = '0;
    if (issue_valid && !stall && !flush) begin
      ent_d[0].vld = 1'b1;
      ent_d[0].wen = issue_wen;
      ent_d[0].wa  = issue_wa;
    end
    for (int k = 1; k < NSTAGES; k++) begin
      if (!(flush && k <= KILL_STAGE)) begin
        ent_d[k].vld = ent_q[k-1].vld;
        ent_d[k].wen = wen_eff[k-1];
        ent_d[k].wa  = ent_q[k-1].wa;
      end
    end
  end

  always_comb begin
    pend_d = '0;
    for (int k = 0; k < NSTAGES; k++)
      pend_d = pend_d + CW'(ent_d[k].vld && (|ent_d[k].wen));
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (clr_cnt)
      stall_cycles_d = '0;
    else if (stall && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q          <= '0;
      pend_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      ent_q          <= ent_d;
      pend_q         <= pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pend_cnt     = pend_q;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_reg_scoreboard_pipe.sv
// Directed bench: default, no-bypass and deep (saturation) scoreboard instances
// share one stimulus stream; each check targets the instance it concerns.

module tb_reg_scoreboard_pipe;
  localparam int AW = 5, NWR = 2, NRD = 2;

  logic              clk = 1'b0, rst = 1'b1;
  logic              issue_valid = 1'b0;
  logic [NWR-1:0]    issue_wen = '0;
  logic [NWR*AW-1:0] issue_wa = '0;
  logic [NRD-1:0]    rd_en = '0;
  logic [NRD*AW-1:0] rd_a = '0;
  logic              cancel = 1'b0, flush = 1'b0, clr_cnt = 1'b0;

  logic        stall_a, stall_b, stall_c;
  logic [2:0]  hz_a, hz_b;
  logic [14:0] hz_c;
  logic [1:0]  pend_a, pend_b;
  logic [3:0]  pend_c;
  logic [15:0] sc_a, sc_b, sc_c;

  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  reg_scoreboard_pipe u_dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_wa(issue_wa), .rd_en(rd_en), .rd_a(rd_a), .cancel(cancel),
    .flush(flush), .clr_cnt(clr_cnt), .stall(stall_a), .hz_stage(hz_a),
    .pend_cnt(pend_a), .stall_cycles(sc_a));

  reg_scoreboard_pipe #(.WT_BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_wa(issue_wa), .rd_en(rd_en), .rd_a(rd_a), .cancel(cancel),
    .flush(flush), .clr_cnt(clr_cnt), .stall(stall_b), .hz_stage(hz_b),
    .pend_cnt(pend_b), .stall_cycles(sc_b));

  reg_scoreboard_pipe #(.NSTAGES(15), .WT_BYPASS(0)) u_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_wa(issue_wa), .rd_en(rd_en), .rd_a(rd_a), .cancel(cancel),
    .flush(flush), .clr_cnt(clr_cnt), .stall(stall_c), .hz_stage(hz_c),
    .pend_cnt(pend_c), .stall_cycles(sc_c));

  typedef struct {
    logic        iv;
    logic [1:0]  wen;
    logic [9:0]  wa;
    logic [1:0]  rden;
    logic [9:0]  rda;
    logic        stall;
    logic [2:0]  hz;
    logic [1:0]  pend;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [9:0] pk(input logic [4:0] a1, input logic [4:0] a0);
    return {a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [1:0] wen, input logic [9:0] wa,
                        input logic [1:0] rden, input logic [9:0] rda);
    issue_valid = iv; issue_wen = wen; issue_wa = wa; rd_en = rden; rd_a = rda;
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 2'b00, 10'd0, 2'b00, 10'd0);
    cancel = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    #2 rst = 1'b1;
    cyc();
  endtask

  initial begin
    // writer r3 then dependent reader; two-port writes; rd_en gating; bypass; self read/write
    tbl[0]  = '{1'b1, 2'b01, pk(5'd0, 5'd3),   2'b00, pk(5'd0, 5'd0),   1'b0, 3'b000, 2'd1, 16'd0};
    tbl[1]  = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b01, pk(5'd0, 5'd3),   1'b1, 3'b001, 2'd1, 16'd1};
    tbl[2]  = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b01, pk(5'd0, 5'd3),   1'b1, 3'b010, 2'd1, 16'd2};
    tbl[3]  = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b01, pk(5'd0, 5'd3),   1'b0, 3'b000, 2'd0, 16'd2};
    tbl[4]  = '{1'b1, 2'b11, pk(5'd9, 5'd4),   2'b00, pk(5'd0, 5'd0),   1'b0, 3'b000, 2'd1, 16'd2};
    tbl[5]  = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b10, pk(5'd9, 5'd4),   1'b1, 3'b001, 2'd1, 16'd3};
    tbl[6]  = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b10, pk(5'd9, 5'd4),   1'b1, 3'b010, 2'd1, 16'd4};
    tbl[7]  = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b10, pk(5'd9, 5'd4),   1'b0, 3'b000, 2'd0, 16'd4};
    tbl[8]  = '{1'b1, 2'b10, pk(5'd12, 5'd0),  2'b00, pk(5'd0, 5'd0),   1'b0, 3'b000, 2'd1, 16'd4};
    tbl[9]  = '{1'b0, 2'b00, pk(5'd0, 5'd0),   2'b01, pk(5'd0, 5'd12),  1'b0, 3'b001, 2'd1, 16'd4};
    tbl[10] = '{1'b1, 2'b01, pk(5'd0, 5'd20),  2'b01, pk(5'd0, 5'd20),  1'b0, 3'b000, 2'd2, 16'd4};
    tbl[11] = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b11, pk(5'd12, 5'd20), 1'b1, 3'b001, 2'd1, 16'd5};
    tbl[12] = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b11, pk(5'd12, 5'd20), 1'b1, 3'b010, 2'd1, 16'd6};
    tbl[13] = '{1'b1, 2'b00, pk(5'd0, 5'd0),   2'b11, pk(5'd12, 5'd20), 1'b0, 3'b000, 2'd0, 16'd6};

    #1 rst = 1'b0;
    #1;
    chk("rst stall", 32'(stall_a), 32'd0);
    chk("rst hz", 32'(hz_a), 32'd0);
    chk("rst pend", 32'(pend_a), 32'd0);
    chk("rst sc", 32'(sc_a), 32'd0);
    #6 rst = 1'b1;
    cyc();

    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].iv, tbl[i].wen, tbl[i].wa, tbl[i].rden, tbl[i].rda);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(stall_a), 32'(tbl[i].stall));
      chk($sformatf("v%0d hz", i), 32'(hz_a), 32'(tbl[i].hz));
      cyc();
      chk($sformatf("v%0d pend", i), 32'(pend_a), 32'(tbl[i].pend));
      chk($sformatf("v%0d sc", i), 32'(sc_a), 32'(tbl[i].sc));
    end

    // no write-through: three stall cycles walking all stages
    do_reset();
    set_in(1'b1, 2'b01, pk(5'd0, 5'd3), 2'b00, 10'd0); cyc();
    set_in(1'b1, 2'b00, 10'd0, 2'b01, pk(5'd0, 5'd3));
    @(negedge clk); chk("nb hz0", 32'(hz_b), 32'b001); chk("nb st0", 32'(stall_b), 32'd1); cyc();
    @(negedge clk); chk("nb hz1", 32'(hz_b), 32'b010); chk("nb st1", 32'(stall_b), 32'd1); cyc();
    @(negedge clk); chk("nb hz2", 32'(hz_b), 32'b100); chk("nb st2", 32'(stall_b), 32'd1); cyc();
    @(negedge clk); chk("nb st3", 32'(stall_b), 32'd0); cyc();
    chk("nb sc", 32'(sc_b), 32'd3);
    chk("byp sc", 32'(sc_a), 32'd2);

    // cancel of the r7 writer at stage 1
    do_reset();
    set_in(1'b1, 2'b01, pk(5'd0, 5'd7), 2'b00, 10'd0); cyc();
    set_in(1'b1, 2'b00, 10'd0, 2'b01, pk(5'd0, 5'd7));
    @(negedge clk); chk("cx pre stall", 32'(stall_a), 32'd1); cyc();
    cancel = 1'b1;
    @(negedge clk);
    chk("cx stall", 32'(stall_a), 32'd0);
    chk("cx hz", 32'(hz_a), 32'd0);
    chk("cx nb stall", 32'(stall_b), 32'd0);
    cyc();
    chk("cx pend", 32'(pend_a), 32'd0);
    cancel = 1'b0;
    @(negedge clk);
    chk("cx stored hz", 32'(hz_b), 32'd0);
    cyc();

    // flush while r5 writer sits in stage 0 and its reader is stalled
    do_reset();
    set_in(1'b1, 2'b01, pk(5'd0, 5'd5), 2'b00, 10'd0); cyc();
    set_in(1'b1, 2'b01, pk(5'd0, 5'd6), 2'b01, pk(5'd0, 5'd5));
    flush = 1'b1;
    @(negedge clk); chk("fl hz", 32'(hz_a), 32'b001); chk("fl stall", 32'(stall_a), 32'd1); cyc();
    chk("fl pend", 32'(pend_a), 32'd0);
    flush = 1'b0;
    @(negedge clk); chk("fl re stall", 32'(stall_a), 32'd0); chk("fl re hz", 32'(hz_a), 32'd0); cyc();
    chk("fl re pend", 32'(pend_a), 32'd1);
    set_in(1'b1, 2'b01, pk(5'd0, 5'd8), 2'b00, 10'd0);
    flush = 1'b1;
    cyc();
    chk("fl sup pend", 32'(pend_a), 32'd0);
    flush = 1'b0;
    set_in(1'b1, 2'b01, pk(5'd0, 5'd9), 2'b00, 10'd0); cyc();
    set_in(1'b1, 2'b01, pk(5'd0, 5'd10), 2'b00, 10'd0); cyc();
    set_in(1'b0, 2'b00, 10'd0, 2'b00, 10'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl keep pend", 32'(pend_a), 32'd1);
    set_in(1'b1, 2'b00, 10'd0, 2'b11, pk(5'd10, 5'd9));
    @(negedge clk);
    chk("fl keep hz nb", 32'(hz_b), 32'b100);
    chk("fl keep hz", 32'(hz_a), 32'd0);
    cyc();

    // async reset while stalled, checked before any clock edge
    do_reset();
    set_in(1'b1, 2'b01, pk(5'd0, 5'd3), 2'b00, 10'd0); cyc();
    set_in(1'b1, 2'b00, 10'd0, 2'b01, pk(5'd0, 5'd3));
    @(negedge clk); chk("ar pre stall", 32'(stall_a), 32'd1); cyc();
    chk("ar pre sc", 32'(sc_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar stall", 32'(stall_a), 32'd0);
    chk("ar hz", 32'(hz_a), 32'd0);
    chk("ar pend", 32'(pend_a), 32'd0);
    chk("ar sc", 32'(sc_a), 32'd0);
    @(negedge clk) rst = 1'b1;
    cyc();

    // 15-stage no-bypass instance stalls 15 of every 16 cycles
    do_reset();
    set_in(1'b1, 2'b01, pk(5'd0, 5'd1), 2'b01, pk(5'd0, 5'd1));
    repeat (70000) @(posedge clk);
    #1;
    chk("sat sc", 32'(sc_c), 32'hFFFF);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr sc", 32'(sc_c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
